i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1000: idle cycles allowed while granted before forced release (used only with I2C_ARB_TIMEOUT_EN).
REQ-002 Parameter TIMEOUT_W, default 16: width of the watchdog counter; TIMEOUT SHALL be < 2^TIMEOUT_W.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1  requester n asks for the I2C byte engine; held high for the whole transaction.
REQ-006 gnt0, gnt1  output  1  requester n owns the engine.
REQ-007 send0, send1  input  1  requester n: transmit next byte while high.
REQ-008 datasend0, datasend1  input  8  requester n: byte to transmit (address+R/W or data).
REQ-009 receive0, receive1  input  1  requester n: receive next byte while high.
REQ-010 sended0, sended1  output  1  byte-accepted strobe routed to requester n.
REQ-011 received0, received1  output  1  byte-ready strobe routed to requester n.
REQ-012 datareceive  output  8  received byte, shared; valid only with received0 or received1.
REQ-013 eng_send, eng_receive  output  1  requests to the byte engine.
REQ-014 eng_datasend  output  8  byte to the byte engine.
REQ-015 eng_sended, eng_received  input  1  engine strobes.
REQ-016 eng_datareceive  input  8  engine received byte.
REQ-017 eng_ready  input  1  engine idle, STOP completed.
REQ-018 timeout_err  output  1  one-cycle pulse on watchdog release.

Function
REQ-019 FSM states SHALL be IDLE, GRANT0, GRANT1, RELEASE.
REQ-020 In IDLE with eng_ready=1, exactly one eligible req -> next state GRANTn.
REQ-021 In IDLE with eng_ready=1, both eligible -> round-robin: requester not granted last wins.
REQ-022 In IDLE with eng_ready=0, no grant is issued.
REQ-023 gnt0 = (state==GRANT0), gnt1 = (state==GRANT1), both registered; never both high.
REQ-024 Last-granted pointer SHALL update on entry to GRANTn.
REQ-025 While in GRANTn: eng_send=sendn, eng_datasend=datasendn, eng_receive=receiven&~sendn (send has priority); combinational, zero latency.
REQ-026 eng_sended/eng_received SHALL route only to the granted requester; non-granted strobes stay 0.
REQ-027 datareceive = eng_datareceive passthrough.
REQ-028 Outside GRANTn: eng_send=0, eng_receive=0, eng_datasend=0; all sended/received outputs 0.
REQ-029 Non-granted requester's send/receive SHALL be ignored.
REQ-030 In GRANTn with reqn=0 -> RELEASE next edge.
REQ-031 RELEASE SHALL last at least one cycle and exit to IDLE on the first cycle with eng_ready=1.
REQ-032 A requester regranted from IDLE still needs eng_ready=1; back-to-back transactions from one requester are allowed when the other is idle.

Reset
REQ-033 On reset: state IDLE, gnt0=gnt1=0, timeout_err=0, pointer = requester 1 (requester 0 wins first tie), watchdog counter 0, eligibility masks cleared.
REQ-034 Reset mid-transaction SHALL drop grants and engine requests on the next edge regardless of engine state.

Configuration
REQ-035 Macro I2C_ARB_TIMEOUT_EN defined: counter cleared on grant entry and on any eng_sended/eng_received; increments each cycle in GRANTn; on reaching TIMEOUT -> RELEASE, timeout_err pulses one cycle, and requester n is ineligible until its req has been seen low.
REQ-036 Macro not defined: no counter logic, timeout_err tied 0, grant held until req drops.

Verification
REQ-037 Reset, req0=1, eng_ready=1 -> gnt0=1 one cycle later; send0=1, datasend0=8'hA0 -> eng_send=1, eng_datasend=8'hA0 same cycle; eng_sended pulse -> sended0=1, sended1=0.
REQ-038 req0=req1=1 simultaneously after reset -> gnt0 first; req0 drops, eng_ready=1 -> gnt1; then req0 again with req1 held through release -> gnt0 (round-robin).
REQ-039 gnt1 active, send0=1, receive1=1 -> eng_send=0, eng_receive=1; eng_received with eng_datareceive=8'h5C -> received1=1, datareceive=8'h5C, received0=0.
REQ-040 req0 drops while eng_ready=0 for 5 cycles -> RELEASE held 5 cycles, no gnt, req1 granted the cycle after eng_ready rises.
REQ-041 With I2C_ARB_TIMEOUT_EN, TIMEOUT=8: gnt0, no engine strobes -> after 8 cycles timeout_err one-cycle pulse, gnt0=0; req0 held high -> no regrant until req0 low then high.
REQ-042 reset asserted during GRANT1 with eng_send=1 -> next edge gnt1=0, eng_send=0, state IDLE.

Source files
------------

// File: rtl/i2c_arbiter.sv
// ============================================================================
// Module   : i2c_arbiter
// Brief    : Round-robin arbiter sharing one I2C byte engine between two
//            requesters; optional watchdog enabled by I2C_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_arbiter #(
  parameter int TIMEOUT   = 1000,
  parameter int TIMEOUT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       send0,
  input  logic       send1,
  input  logic [7:0] datasend0,
  input  logic [7:0] datasend1,
  input  logic       receive0,
  input  logic       receive1,
  output logic       sended0,
  output logic       sended1,
  output logic       received0,
  output logic       received1,
  output logic [7:0] datareceive,
  output logic       eng_send,
  output logic       eng_receive,
  output logic [7:0] eng_datasend,
  input  logic       eng_sended,
  input  logic       eng_received,
  input  logic [7:0] eng_datareceive,
  input  logic       eng_ready,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  if (TIMEOUT >= (1 << TIMEOUT_W)) begin : g_timeout_range_check
    $error("i2c_arbiter: TIMEOUT does not fit in TIMEOUT_W bits");
  end

  state_t state_q;
  logic   gnt0_q;
  logic   gnt1_q;
  logic   last_q;   // 1: requester 1 was granted most recently
  logic   elig0;
  logic   elig1;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] C_CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 inelig0_q;
  logic                 inelig1_q;
  logic                 timeout_err_q;
  logic                 strobe;

  assign elig0       = req0 & ~inelig0_q;
  assign elig1       = req1 & ~inelig1_q;
  assign strobe      = eng_sended | eng_received;
  assign timeout_err = timeout_err_q;
`else
  assign elig0       = req0;
  assign elig1       = req1;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      last_q        <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      inelig0_q     <= 1'b0;
      inelig1_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
      // A timed-out requester becomes eligible again once it drops req.
      if (!req0) inelig0_q <= 1'b0;
      if (!req1) inelig1_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (eng_ready && (elig0 || elig1)) begin
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q <= '0;
`endif
            if (elig0 && (!elig1 || last_q)) begin
              state_q <= GRANT0;
              gnt0_q  <= 1'b1;
              last_q  <= 1'b0;
            end else begin
              state_q <= GRANT1;
              gnt1_q  <= 1'b1;
              last_q  <= 1'b1;
            end
          end
        end
        GRANT0: begin
          if (!req0) begin
            state_q <= RELEASE;
            gnt0_q  <= 1'b0;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (strobe) begin
            cnt_q <= '0;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q       <= RELEASE;
            gnt0_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            inelig0_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        GRANT1: begin
          if (!req1) begin
            state_q <= RELEASE;
            gnt1_q  <= 1'b0;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (strobe) begin
            cnt_q <= '0;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q       <= RELEASE;
            gnt1_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            inelig1_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (eng_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign datareceive = eng_datareceive;

  // Zero-latency steering of the granted requester onto the engine.
  always_comb begin
    eng_send     = 1'b0;
    eng_receive  = 1'b0;
    eng_datasend = 8'd0;
    sended0      = 1'b0;
    sended1      = 1'b0;
    received0    = 1'b0;
    received1    = 1'b0;
    if (gnt0_q) begin
      eng_send     = send0;
      eng_receive  = receive0 & ~send0;
      eng_datasend = datasend0;
      sended0      = eng_sended;
      received0    = eng_received;
    end else if (gnt1_q) begin
      eng_send     = send1;
      eng_receive  = receive1 & ~send1;
      eng_datasend = datasend1;
      sended1      = eng_sended;
      received1    = eng_received;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
// ============================================================================
// Module   : tb_i2c_arbiter
// Brief    : Directed self-checking bench for i2c_arbiter (scoreboard queue).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, gnt0, gnt1;
  logic       send0, send1, receive0, receive1;
  logic [7:0] datasend0, datasend1;
  logic       sended0, sended1, received0, received1;
  logic [7:0] datareceive;
  logic       eng_send, eng_receive;
  logic [7:0] eng_datasend;
  logic       eng_sended, eng_received, eng_ready;
  logic [7:0] eng_datareceive;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  i2c_arbiter #(.TIMEOUT(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .send0(send0), .send1(send1),
    .datasend0(datasend0), .datasend1(datasend1),
    .receive0(receive0), .receive1(receive1),
    .sended0(sended0), .sended1(sended1),
    .received0(received0), .received1(received1),
    .datareceive(datareceive),
    .eng_send(eng_send), .eng_receive(eng_receive),
    .eng_datasend(eng_datasend),
    .eng_sended(eng_sended), .eng_received(eng_received),
    .eng_datareceive(eng_datareceive), .eng_ready(eng_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic ck(input logic [7:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: observed %h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic ck1(input logic b);
    ck({7'd0, b});
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    send0 = 1'b0; send1 = 1'b0; receive0 = 1'b0; receive1 = 1'b0;
    datasend0 = 8'd0; datasend1 = 8'd0;
    eng_sended = 1'b0; eng_received = 1'b0; eng_ready = 1'b0;
    eng_datareceive = 8'd0;
    tick(); tick();
    ex("rst_gnt0", 0);        ck1(gnt0);
    ex("rst_gnt1", 0);        ck1(gnt1);
    ex("rst_timeout_err", 0); ck1(timeout_err);
    ex("rst_eng_send", 0);    ck1(eng_send);
    ex("rst_eng_receive", 0); ck1(eng_receive);
    reset = 1'b0;

    // No grant while the engine is busy
    req0 = 1'b1; eng_ready = 1'b0;
    ex("busy_no_gnt0", 0); tick(); ck1(gnt0);

    // Single requester, send path and strobe routing
    eng_ready = 1'b1;
    ex("gnt0_single", 1); ex("gnt1_single", 0);
    tick(); ck1(gnt0); ck1(gnt1);
    send0 = 1'b1; datasend0 = 8'hA0; receive0 = 1'b1;
    ex("eng_send_g0", 1); ex("eng_datasend_g0", 8'hA0); ex("send_prio", 0);
    #1; ck1(eng_send); ck(eng_datasend); ck1(eng_receive);
    eng_sended = 1'b1;
    ex("sended0", 1); ex("sended1", 0);
    #1; ck1(sended0); ck1(sended1);
    eng_sended = 1'b0; send0 = 1'b0; receive0 = 1'b0;
    send1 = 1'b1; datasend1 = 8'h33;
    ex("ignore_send1", 0); #1; ck1(eng_send);
    send1 = 1'b0;
    req0 = 1'b0;
    ex("release_gnt0", 0); ex("release_datasend", 0);
    tick(); ck1(gnt0); ck(eng_datasend);
    tick();

    // Simultaneous requests then round-robin
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    ex("tie_gnt0", 1); ex("tie_gnt1", 0);
    tick(); ck1(gnt0); ck1(gnt1);
    req0 = 1'b0;
    ex("rr_gnt1", 1); ex("rr_gnt0_off", 0);
    tick(); tick(); tick(); ck1(gnt1); ck1(gnt0);
    req0 = 1'b1; req1 = 1'b0;
    tick();
    req1 = 1'b1;
    ex("rr_back_gnt0", 1); ex("rr_back_gnt1", 0);
    tick(); tick(); ck1(gnt0); ck1(gnt1);

    // Receive path on requester 1
    req0 = 1'b0;
    ex("g1_again", 1);
    tick(); tick(); tick(); ck1(gnt1);
    send0 = 1'b1; receive1 = 1'b1;
    ex("ng_send_blocked", 0); ex("eng_receive_g1", 1);
    #1; ck1(eng_send); ck1(eng_receive);
    eng_received = 1'b1; eng_datareceive = 8'h5C;
    ex("received1", 1); ex("datareceive", 8'h5C); ex("received0", 0);
    #1; ck1(received1); ck(datareceive); ck1(received0);
    eng_received = 1'b0; send0 = 1'b0; receive1 = 1'b0;

    // Reset mid-transaction
    send1 = 1'b1;
    ex("g1_send", 1); #1; ck1(eng_send);
    reset = 1'b1;
    ex("midrst_gnt1", 0); ex("midrst_send", 0);
    tick(); ck1(gnt1); ck1(eng_send);
    reset = 1'b0; send1 = 1'b0;
    ex("post_rst_gnt1", 1); tick(); ck1(gnt1);

    // RELEASE held while engine busy
    req1 = 1'b0; tick(); tick();
    req0 = 1'b1;
    ex("pre_hold_gnt0", 1); tick(); ck1(gnt0);
    req1 = 1'b1; eng_ready = 1'b0; req0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ex("hold_no_gnt", 0);
      tick(); ck1(gnt0 | gnt1);
    end
    eng_ready = 1'b1;
    ex("after_hold_gnt1", 1);
    tick(); tick(); ck1(gnt1);

`ifdef I2C_ARB_TIMEOUT_EN
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; tick(); reset = 1'b0;
    req0 = 1'b1;
    ex("to_gnt0", 1); tick(); ck1(gnt0);
    for (int i = 0; i < 7; i++) begin
      ex("to_wait", 1);
      tick(); ck1(gnt0 & ~timeout_err);
    end
    ex("to_pulse", 1); ex("to_gnt0_drop", 0);
    tick(); ck1(timeout_err); ck1(gnt0);
    ex("to_pulse_end", 0); tick(); ck1(timeout_err);
    ex("to_no_regrant", 0); tick(); tick(); ck1(gnt0);
    req0 = 1'b0; tick();
    req0 = 1'b1;
    ex("to_regrant", 1); tick(); ck1(gnt0);
`endif

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: observed %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
